// File: rtl/aer_event_packer.sv
// aer_event_packer: timestamps arbiter grants, inserts rollover markers and buffers address-events in a FIFO
module aer_event_packer #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int TS_W = 12,
  parameter int DEPTH = 8,
  parameter int DROP_W = 8,
  localparam int X_W = $clog2(ROWS),
  localparam int Y_W = $clog2(COLS),
  localparam int W = 1 + TS_W + X_W + Y_W,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic              active_i,
  input  logic [X_W-1:0]    x_add_i,
  input  logic [Y_W-1:0]    y_add_i,
  output logic [W-1:0]      evt_data_o,
  output logic              evt_valid_o,
  input  logic              evt_ready_i,
  output logic [AW:0]       fifo_level_o,
  output logic              overflow_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  input  logic              clear_i
);
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              pend_q, pend_d, act_q, act_d, ovf_q, ovf_d;
  logic [X_W-1:0]    lx_q, lx_d;
  logic [Y_W-1:0]    ly_q, ly_d;
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]       lvl_q, lvl_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      word;
  logic              cap, mrk, push, pop, full, wr, drop, wrap;
  assign evt_valid_o  = lvl_q != '0;
  assign evt_data_o   = evt_valid_o ? mem[rp_q] : '0;
  assign fifo_level_o = lvl_q;
  assign overflow_o   = ovf_q;
  assign drop_cnt_o   = drop_q;
  assign pop  = evt_valid_o & evt_ready_i;
  assign full = lvl_q == (AW+1)'(DEPTH);
  assign cap  = enable_i & active_i & (!act_q | x_add_i != lx_q | y_add_i != ly_q);
  assign mrk  = enable_i & pend_q & !cap;
  assign push = cap | mrk;
  assign wr   = push & (!full | pop);
  assign drop = push & full & !pop;
  assign wrap = enable_i & (&ts_q);
  assign word = cap ? {1'b0, ts_q, x_add_i, y_add_i} : {1'b1, (W-1)'(0)};
  // next-state: timestamp, rollover pending, grant edge detect, FIFO pointers and drop accounting
  always_comb begin
    ts_d   = enable_i ? ts_q + TS_W'(1) : ts_q;
    pend_d = wrap | (pend_q & !mrk);
    act_d  = enable_i & active_i;
    lx_d   = cap ? x_add_i : lx_q;
    ly_d   = cap ? y_add_i : ly_q;
    wp_d   = wr ? wp_q + AW'(1) : wp_q;
    rp_d   = pop ? rp_q + AW'(1) : rp_q;
    lvl_d  = (wr & !pop) ? lvl_q + (AW+1)'(1) : (pop & !wr) ? lvl_q - (AW+1)'(1) : lvl_q;
    ovf_d  = !clear_i & (ovf_q | drop);
    drop_d = clear_i ? '0 : (drop & !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
  end
  // state registers, flushed asynchronously by reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q   <= '0;
      pend_q <= 1'b0;
      act_q  <= 1'b0;
      lx_q   <= '0;
      ly_q   <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      ts_q   <= ts_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      lx_q   <= lx_d;
      ly_q   <= ly_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end
  // FIFO storage; contents are don't-care until written since output is gated by valid
  always_ff @(posedge clk_i) begin
    if (wr) mem[wp_q] <= word;
  end
endmodule

// File: tb/tb_aer_event_packer.sv
// tb_aer_event_packer: directed stimulus with a scoreboard queue checked by a handshake monitor
module tb_aer_event_packer;
  localparam int TS_W = 12;
  localparam int W = 1 + TS_W + 2 + 2;
  localparam logic [W-1:0] MARK = {1'b1, 16'h0};
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0, active = 1'b0, ready = 1'b0, clear = 1'b0;
  logic [1:0] xa = '0, ya = '0;
  logic [W-1:0] evt_data;
  logic evt_valid, overflow;
  logic [3:0] level;
  logic [7:0] drop_cnt;
  logic [TS_W-1:0] ts_m = '0;
  logic [W-1:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  aer_event_packer #(.ROWS(4), .COLS(4), .TS_W(TS_W), .DEPTH(8), .DROP_W(8)) dut (
    .clk_i(clk), .reset_ni(reset_n), .enable_i(enable), .active_i(active),
    .x_add_i(xa), .y_add_i(ya), .evt_data_o(evt_data), .evt_valid_o(evt_valid),
    .evt_ready_i(ready), .fifo_level_o(level), .overflow_o(overflow),
    .drop_cnt_o(drop_cnt), .clear_i(clear)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  function automatic logic [W-1:0] mk(input logic [TS_W-1:0] t, input logic [1:0] x, input logic [1:0] y);
    return {1'b0, t, x, y};
  endfunction
  // every accepted word is compared against the oldest expected word
  always @(negedge clk) begin
    if (reset_n && evt_valid && ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got=%h want=none", evt_data);
      end else chk("word", 32'(evt_data), 32'(q.pop_front()));
    end
  end
  task automatic step(input logic en, input logic act, input logic [1:0] x, input logic [1:0] y, input logic exp);
    enable = en;
    active = act;
    xa = x;
    ya = y;
    if (exp) q.push_back(mk(ts_m, x, y));
    @(posedge clk);
    #1;
    if (en) ts_m++;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    active = 1'b0;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ts_m = '0;
    q.delete();
  endtask
  task automatic drain(input string n);
    ready = 1'b1;
    for (int i = 0; i < 100 && evt_valid; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
    chk({n, "_valid_low"}, 32'(evt_valid), 0);
    chk({n, "_sb_empty"}, q.size(), 0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset();
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_data", 32'(evt_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    // held grant yields one word, valid right after the capture edge
    ready = 1'b1;
    step(1, 1, 2'd2, 2'd1, 1);
    chk("t1_valid_after_cap", 32'(evt_valid), 1);
    chk("t1_head", 32'(evt_data), 32'(mk(12'd0, 2'd2, 2'd1)));
    repeat (4) step(1, 1, 2'd2, 2'd1, 0);
    step(1, 0, 2'd0, 2'd0, 0);
    drain("t1");
    // address change while active stays high
    step(1, 1, 2'd2, 2'd1, 1);
    step(1, 1, 2'd2, 2'd3, 1);
    repeat (3) step(1, 1, 2'd2, 2'd3, 0);
    step(1, 0, 2'd0, 2'd0, 0);
    drain("t2");
    // overflow: 10 events into 8 entries, then clear
    ready = 1'b0;
    for (int i = 0; i < 10; i++) step(1, 1, 2'(i % 4), 2'(i / 4), i < 8);
    step(1, 0, 2'd0, 2'd0, 0);
    chk("t3_level", 32'(level), 8);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_drop", 32'(drop_cnt), 2);
    chk("t3_head_hold", 32'(evt_data), 32'(q[0]));
    clear = 1'b1;
    step(1, 0, 2'd0, 2'd0, 0);
    clear = 1'b0;
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_clr_drop", 32'(drop_cnt), 0);
    chk("t3_clr_level", 32'(level), 8);
    // full FIFO push and pop together, then drop saturation and clear-wins
    ready = 1'b1;
    step(1, 1, 2'd3, 2'd3, 1);
    ready = 1'b0;
    chk("t5_level_full", 32'(level), 8);
    chk("t5_no_drop", 32'(drop_cnt), 0);
    chk("t5_no_ovf", 32'(overflow), 0);
    for (int i = 0; i < 256; i++) step(1, 1, 2'(i % 2), 2'd0, 0);
    chk("t5_drop_sat", 32'(drop_cnt), 255);
    chk("t5_ovf", 32'(overflow), 1);
    clear = 1'b1;
    step(1, 1, 2'd2, 2'd0, 0);
    clear = 1'b0;
    chk("t5_clr_win_drop", 32'(drop_cnt), 0);
    chk("t5_clr_win_ovf", 32'(overflow), 0);
    step(1, 0, 2'd0, 2'd0, 0);
    drain("t5");
    // rollover marker alone, then wrap coinciding with captures
    do_reset();
    ready = 1'b1;
    while (ts_m != '1) step(1, 0, 2'd0, 2'd0, 0);
    step(1, 0, 2'd0, 2'd0, 0);
    q.push_back(MARK);
    step(1, 0, 2'd0, 2'd0, 0);
    repeat (3) step(1, 0, 2'd0, 2'd0, 0);
    drain("t4a");
    while (ts_m != '1) step(1, 0, 2'd0, 2'd0, 0);
    step(1, 1, 2'd3, 2'd2, 1);
    step(1, 1, 2'd0, 2'd1, 1);
    q.push_back(MARK);
    step(1, 1, 2'd0, 2'd1, 0);
    repeat (3) step(1, 0, 2'd0, 2'd0, 0);
    drain("t4b");
    // asynchronous reset with words queued
    do_reset();
    ready = 1'b0;
    step(1, 1, 2'd0, 2'd0, 0);
    step(1, 1, 2'd1, 2'd0, 0);
    step(1, 1, 2'd2, 2'd0, 0);
    step(1, 0, 2'd0, 2'd0, 0);
    chk("t6_level_pre", 32'(level), 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(evt_valid), 0);
    chk("t6_level_rst", 32'(level), 0);
    chk("t6_data_rst", 32'(evt_data), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    ts_m = '0;
    enable = 1'b0;
    active = 1'b0;
    ready = 1'b1;
    step(1, 1, 2'd3, 2'd3, 1);
    step(1, 0, 2'd0, 2'd0, 0);
    drain("t6");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
